// File: rtl/ula_multiciclo.sv
// Registered multi-cycle ALU with a start/done handshake: simple ops finish in
// one cycle, multiply/divide iterate one result bit per cycle.
module ula_multiciclo #(
  parameter  int LARGURA = 32,
  localparam int CONT_W  = $clog2(LARGURA + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [3:0]         ulaControle,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  output logic               ocupado,
  output logic               pronto,
  output logic [LARGURA-1:0] ulaSaida,
  output logic               zero,
  output logic               divZero
);

  // FIM is the cycle pronto is high for an iterative op; it accepts inicio like OCIOSO.
  typedef enum logic [1:0] {OCIOSO, MULT, DIV, FIM} estado_t;

  estado_t            estado, estado_prox;
  logic               sel_alta;
  logic [LARGURA-1:0] operando, acumulador, deslocador;
  logic [CONT_W-1:0]  contador;

  logic livre, eh_iterativo, eh_div, b_nulo;

  assign livre        = (estado == OCIOSO) || (estado == FIM);
  assign eh_iterativo = (ulaControle[3:2] == 2'b11);
  assign eh_div       = eh_iterativo && ulaControle[0];
  assign b_nulo       = (B == '0);
  assign ocupado      = !livre;

  logic [LARGURA-1:0] res_simples;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    res_simples = '0;
    case (ulaControle)
      4'd0:    res_simples = A + B;
      4'd1:    res_simples = A - B;
      4'd2:    res_simples = A & B;
      4'd3:    res_simples = A | B;
      4'd4:    res_simples = ~A;
      4'd5:    res_simples = A >> 1;
      4'd6:    res_simples = A << 1;
      4'd7:    res_simples = LARGURA'(A < B);
      4'd8:    res_simples = LARGURA'(A == B);
      4'd9:    res_simples = LARGURA'(A > B);
      4'd10:   res_simples = LARGURA'(A <= B);
      4'd11:   res_simples = LARGURA'(A >= B);
      default: res_simples = '0;
    endcase
  end

  // Shift-add step: {acumulador, deslocador} is the 2*LARGURA product register.
  logic [LARGURA:0]   soma;
  logic [LARGURA-1:0] acc_mult, desl_mult;

  assign soma      = {1'b0, acumulador} + (deslocador[0] ? {1'b0, operando} : '0);
  assign acc_mult  = soma[LARGURA:1];
  assign desl_mult = {soma[0], deslocador[LARGURA-1:1]};

  // Restoring step: the remainder stays below the divisor, so the borrow bit decides.
  logic [LARGURA:0]   tentativa, diferenca;
  logic               cabe;
  logic [LARGURA-1:0] acc_div, desl_div;

  assign tentativa = {acumulador, deslocador[LARGURA-1]};
  assign diferenca = tentativa - {1'b0, operando};
  assign cabe      = !diferenca[LARGURA];
  assign acc_div   = cabe ? diferenca[LARGURA-1:0] : tentativa[LARGURA-1:0];
  assign desl_div  = {deslocador[LARGURA-2:0], cabe};

  logic [LARGURA-1:0] acc_passo, desl_passo;

  assign acc_passo  = (estado == DIV) ? acc_div  : acc_mult;
  assign desl_passo = (estado == DIV) ? desl_div : desl_mult;

  logic               carrega_op, carrega_saida, iterando, dz_prox;
  logic [LARGURA-1:0] saida_prox;

  always_comb begin
    estado_prox   = estado;
    carrega_op    = 1'b0;
    carrega_saida = 1'b0;
    iterando      = 1'b0;
    dz_prox       = 1'b0;
    saida_prox    = res_simples;
    case (estado)
      OCIOSO, FIM: begin
        estado_prox = OCIOSO;
        if (inicio) begin
          if (eh_iterativo && !(eh_div && b_nulo)) begin
            carrega_op  = 1'b1;
            estado_prox = eh_div ? DIV : MULT;
          end else begin
            carrega_saida = 1'b1;
            if (eh_div) begin
              dz_prox    = 1'b1;
              saida_prox = ulaControle[1] ? A : '1;
            end
          end
        end
      end
      MULT, DIV: begin
        iterando = 1'b1;
        // The last iteration writes the result directly, so FIM is the pronto cycle.
        if (contador == CONT_W'(1)) begin
          estado_prox   = FIM;
          carrega_saida = 1'b1;
          saida_prox    = sel_alta ? acc_passo : desl_passo;
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= estado_prox;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_alta   <= 1'b0;
      operando   <= '0;
      acumulador <= '0;
      deslocador <= '0;
      contador   <= '0;
      pronto     <= 1'b0;
      ulaSaida   <= '0;
      zero       <= 1'b0;
      divZero    <= 1'b0;
    end else begin
      pronto <= carrega_saida;
      if (carrega_op) begin
        sel_alta   <= ulaControle[1];
        contador   <= CONT_W'(LARGURA);
        acumulador <= '0;
        operando   <= eh_div ? B : A;
        deslocador <= eh_div ? A : B;
      end else if (iterando) begin
        contador   <= contador - CONT_W'(1);
        acumulador <= acc_passo;
        deslocador <= desl_passo;
      end
      if (carrega_saida) begin
        ulaSaida <= saida_prox;
        zero     <= (saida_prox == '0);
        divZero  <= dz_prox;
      end
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo at LARGURA=32 and LARGURA=8; expected results
// are queued at issue time and compared, with latency, when pronto appears.
module tb_ula_multiciclo;

  typedef struct {
    string       tag;
    logic [31:0] saida;
    logic        zero;
    logic        dz;
    int          emitido;
    int          lat;
  } esperado_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        inicio32, inicio8;
  logic [3:0]  op32, op8;
  logic [31:0] a32, b32, saida32;
  logic [7:0]  a8, b8, saida8;
  logic        ocupado32, pronto32, zero32, dz32;
  logic        ocupado8, pronto8, zero8, dz8;

  ula_multiciclo #(.LARGURA(32)) dut32 (
    .clock(clock), .reset(reset), .inicio(inicio32), .ulaControle(op32),
    .A(a32), .B(b32), .ocupado(ocupado32), .pronto(pronto32),
    .ulaSaida(saida32), .zero(zero32), .divZero(dz32)
  );

  ula_multiciclo #(.LARGURA(8)) dut8 (
    .clock(clock), .reset(reset), .inicio(inicio8), .ulaControle(op8),
    .A(a8), .B(b8), .ocupado(ocupado8), .pronto(pronto8),
    .ulaSaida(saida8), .zero(zero8), .divZero(dz8)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int total = 0, passed = 0, fails = 0;
  esperado_t fila32[$], fila8[$];
  esperado_t e32, e8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic confere(input esperado_t e, input logic [31:0] s, input logic z, input logic d);
    check({e.tag, "_saida"}, s, e.saida);
    check({e.tag, "_zero"}, 32'(z), 32'(e.zero));
    check({e.tag, "_divzero"}, 32'(d), 32'(e.dz));
    check({e.tag, "_latencia"}, 32'(cyc - e.emitido), 32'(e.lat));
  endtask

  always @(negedge clock) begin
    if (pronto32) begin
      check("pronto32_com_pedido", 32'(fila32.size() != 0), 32'd1);
      if (fila32.size() != 0) begin
        e32 = fila32.pop_front();
        confere(e32, saida32, zero32, dz32);
      end
    end
    if (pronto8) begin
      check("pronto8_com_pedido", 32'(fila8.size() != 0), 32'd1);
      if (fila8.size() != 0) begin
        e8 = fila8.pop_front();
        confere(e8, {24'b0, saida8}, zero8, dz8);
      end
    end
  end

  function automatic logic [31:0] modelo(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ~a;
      4'd5:  return a >> 1;
      4'd6:  return a << 1;
      4'd7:  return {31'b0, a < b};
      4'd8:  return {31'b0, a == b};
      4'd9:  return {31'b0, a > b};
      4'd10: return {31'b0, a <= b};
      4'd11: return {31'b0, a >= b};
      4'd12: return p[31:0];
      4'd14: return p[63:32];
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic emite32(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic dz, input int lat);
    esperado_t e;
    e.tag = tag; e.saida = exp; e.zero = (exp == 32'd0); e.dz = dz; e.emitido = cyc; e.lat = lat;
    fila32.push_back(e);
    inicio32 = 1'b1; op32 = op; a32 = a; b32 = b;
    tick(1);
    inicio32 = 1'b0;
  endtask

  task automatic emite8(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp, input logic dz, input int lat);
    esperado_t e;
    e.tag = tag; e.saida = {24'b0, exp}; e.zero = (exp == 8'd0); e.dz = dz; e.emitido = cyc; e.lat = lat;
    fila8.push_back(e);
    inicio8 = 1'b1; op8 = op; a8 = a; b8 = b;
    tick(1);
    inicio8 = 1'b0;
  endtask

  task automatic drena(input string tag, input int limite);
    for (int i = 0; i < limite; i++) begin
      if (fila32.size() == 0 && fila8.size() == 0) break;
      tick(1);
    end
    check({tag, "_drenado"}, 32'(fila32.size() + fila8.size()), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        dz;

    reset = 1'b0;
    inicio32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    inicio8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("reset_saida32", saida32, 32'd0);
    check("reset_zero32", 32'(zero32), 32'd0);
    check("reset_dz32", 32'(dz32), 32'd0);
    check("reset_pronto32", 32'(pronto32), 32'd0);
    check("reset_ocupado32", 32'(ocupado32), 32'd0);
    check("reset_saida8", {24'b0, saida8}, 32'd0);
    check("reset_ocupado8", 32'(ocupado8), 32'd0);

    // Leave a nonzero result behind, then abort a multiply with reset.
    emite32("nao", 4'd4, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    drena("pre_abort", 5);
    emite32("mult_abortada", 4'd12, 32'd7, 32'd9, 32'd63, 1'b0, 33);
    tick(4);
    check("abort_ocupado_antes", 32'(ocupado32), 32'd1);
    reset = 1'b0;
    #1;
    fila32.delete();
    check("abort_saida", saida32, 32'd0);
    check("abort_ocupado", 32'(ocupado32), 32'd0);
    check("abort_pronto", 32'(pronto32), 32'd0);
    tick(1);
    reset = 1'b1;
    tick(40);
    check("pos_abort_ocupado", 32'(ocupado32), 32'd0);
    check("pos_abort_saida", saida32, 32'd0);

    // Back-to-back simple ops, one per cycle.
    emite32("soma_estouro", 4'd0,  32'hFFFF_FFFF, 32'd1, 32'd0,         1'b0, 1);
    emite32("sub",          4'd1,  32'd3,         32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    emite32("menor",        4'd7,  32'd2,         32'd9, 32'd1,         1'b0, 1);
    emite32("shr",          4'd5,  32'h8000_0001, 32'd0, 32'h4000_0000, 1'b0, 1);
    emite32("shl",          4'd6,  32'h8000_0001, 32'd0, 32'h0000_0002, 1'b0, 1);
    emite32("igual",        4'd8,  32'd9,         32'd9, 32'd1,         1'b0, 1);
    emite32("maior",        4'd9,  32'd3,         32'd9, 32'd0,         1'b0, 1);
    emite32("menor_igual",  4'd10, 32'd9,         32'd9, 32'd1,         1'b0, 1);
    emite32("maior_igual",  4'd11, 32'd8,         32'd9, 32'd0,         1'b0, 1);
    emite32("and",          4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
    emite32("or",           4'd3,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1);
    drena("simples", 10);

    // Multiply; an inicio while busy must be ignored and operands may change.
    emite32("mult_baixo", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
    tick(5);
    inicio32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
    check("mult_ocupado", 32'(ocupado32), 32'd1);
    tick(1);
    inicio32 = 1'b0; a32 = $urandom; b32 = $urandom;
    tick(26);
    check("mult_pronto_ciclo", 32'(pronto32), 32'd1);
    check("mult_livre_no_pronto", 32'(ocupado32), 32'd0);
    emite32("mult_alto", 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    drena("mult", 40);
    tick(3);
    check("retencao_saida", saida32, 32'hFFFF_FFFE);

    // Divide, then divide by zero.
    emite32("quociente", 4'd13, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    drena("quociente", 40);
    emite32("resto", 4'd15, 32'd100, 32'd7, 32'd2, 1'b0, 33);
    drena("resto", 40);
    emite32("div0_q",     4'd13, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    emite32("div0_r",     4'd15, 32'd5, 32'd0, 32'd5,         1'b1, 1);
    emite32("div0_limpa", 4'd0,  32'd1, 32'd2, 32'd3,         1'b0, 1);
    drena("div0", 10);

    // A few random operations through the reference model.
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      dz = (op == 4'd13 || op == 4'd15) && (b == 32'd0);
      emite32($sformatf("aleat%0d_op%0d", i, op), op, a, b, modelo(op, a, b), dz,
              (op >= 4'd12 && !dz) ? 33 : 1);
      drena("aleat", 40);
    end

    // Narrow instance.
    emite8("m8_baixo", 4'd12, 8'h10, 8'h10, 8'h00, 1'b0, 9);
    drena("m8_baixo", 15);
    emite8("m8_alto", 4'd14, 8'h10, 8'h10, 8'h01, 1'b0, 9);
    drena("m8_alto", 15);
    emite8("d8_q", 4'd13, 8'hFF, 8'h10, 8'h0F, 1'b0, 9);
    drena("d8_q", 15);
    emite8("d8_r", 4'd15, 8'hFF, 8'h10, 8'h0F, 1'b0, 9);
    drena("d8_r", 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
Parametrised, registered successor to the datapath's combinational ALU. It keeps the 4-bit operation encoding and adds a start/done handshake. Simple operations complete in one cycle; multiply and divide are iterative, one result bit per cycle. It sits between the register-file read stage and write-back, and the control unit stalls on ocupado.

Parameters:
LARGURA, 32, operand/result width in bits (>=4)
CONT_W, $clog2(LARGURA+1), iteration counter width (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
inicio  input  1  start strobe; accepted only when ocupado=0
ulaControle  input  4  operation code, sampled with inicio
A  input  LARGURA  operand A, sampled with inicio
B  input  LARGURA  operand B, sampled with inicio
ocupado  output  1  high from the cycle after acceptance until pronto
pronto  output  1  one-cycle pulse, ulaSaida valid
ulaSaida  output  LARGURA  registered result, held until next pronto
zero  output  1  ulaSaida==0, updated with pronto
divZero  output  1  set with pronto for ops 13/15 when B==0, else cleared with pronto

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO, ocupado=0, pronto=0, ulaSaida=0, zero=0, divZero=0, counter and internal operand registers 0.
- Reset asserted mid-operation aborts the operation. No pronto is issued for it.
- All arithmetic is unsigned and results are truncated to LARGURA bits.
- Operation encoding:
  - 0 A+B, 1 A-B, 2 A&B, 3 A|B, 4 ~A
  - 5 A>>1, 6 A<<1 (logical shifts)
  - 7 A<B, 8 A==B, 9 A>B, 10 A<=B, 11 A>=B (compare ops produce 1 or 0, zero-extended)
  - 12 low LARGURA bits of A*B, 14 high LARGURA bits of A*B
  - 13 quotient A/B, 15 remainder A%B
- States: OCIOSO, MULT, DIV, FIM.
- OCIOSO:
  - inicio=1 with simple op (0-11): result registered at the next edge, pronto=1 that cycle, stay OCIOSO. Latency 1; ocupado stays 0.
  - inicio=1 with op 12/14: latch A, B, op; clear accumulator; counter=LARGURA; go to MULT; ocupado=1.
  - inicio=1 with op 13/15 and B!=0: latch operands; remainder=0; counter=LARGURA; go to DIV; ocupado=1.
  - inicio=1 with op 13/15 and B==0: no iteration. Next edge: ulaSaida = all ones (op 13) or A (op 15), divZero=1, pronto=1.
- MULT: shift-add, one multiplier bit per cycle, 2*LARGURA-bit product. Counter decrements; at 0 go to FIM.
- DIV: restoring division, one quotient bit per cycle. Counter decrements; at 0 go to FIM.
- FIM: load ulaSaida with the selected word, update zero and divZero, pronto=1, ocupado=0, return to OCIOSO.
- Latency, inicio edge to pronto, for ops 12-15 with B!=0: LARGURA+1 cycles.
- inicio while ocupado=1 is ignored; the in-flight operation and its latched operands are unaffected.
- inicio may be asserted in the same cycle pronto is high, since ocupado=0 then. It is accepted, giving back-to-back throughput of one op per cycle for simple ops.
- A, B and ulaControle may change freely after acceptance.
- pronto is never high for two consecutive cycles from one operation.
- ulaSaida, zero and divZero change only on a pronto cycle.

Test Plan:
1. Reset: reset=0 for 3 cycles, then release -> all outputs 0, ocupado=0. Then pulse reset=0 mid-MULT -> outputs 0, no pronto, next op runs normally.
2. Simple ops, LARGURA=32, one inicio per cycle:
   - op 0, A=0xFFFFFFFF, B=1 -> ulaSaida=0, zero=1, pronto next cycle
   - op 1, A=3, B=5 -> 0xFFFFFFFE
   - op 7, A=2, B=9 -> 1
   - op 5, A=0x80000001 -> 0x40000000
   - check pronto on each consecutive cycle
3. Multiply: op 12 and then op 14 with A=0xFFFFFFFF, B=0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE, each pronto exactly 33 cycles after inicio. During the run, inicio with op 0 is ignored and the results are unchanged.
4. Divide: op 13, A=100, B=7 -> 14; op 15 -> 2; divZero=0; latency 33 cycles.
5. Divide by zero: op 13, A=5, B=0 -> 0xFFFFFFFF, divZero=1, latency 1. Then op 15, A=5, B=0 -> 5, divZero=1. A following op 0 -> divZero=0.
6. Parameter sweep, LARGURA=8:
   - op 12, A=0x10, B=0x10 -> 0x00; op 14 -> 0x01
   - op 13, A=0xFF, B=0x10 -> 0x0F
   - pronto 9 cycles after inicio
